stack_lifo_param: RTL and testbench

Parametrised LIFO stack, the next generation of the existing fixed 32-bit stack. Depth and width are configurable. It adds an occupancy count, same-cycle push+pop (replace-top / bypass), a registered pop output with a valid strobe, sticky overflow/underflow error flags and a synchronous clear. It sits between a producer and a consumer that need last-in-first-out buffering, for example expression evaluation or return-address storage.

---
 rtl/stack_lifo_param.sv | 171 +++++++++++++++++
 tb/tb_stack_lifo_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_lifo_param.sv
// -----------------------------------------------------------------------------
// stack_lifo_param
//
// Parametrised last-in-first-out stack with occupancy count, level flags,
// same-cycle push+pop (replace-top when non-empty, bypass when empty), a
// registered pop output with a one-cycle valid strobe, sticky overflow and
// underflow flags, and a synchronous clear.
//
// Parameters
//   WIDTH  data word width (>= 1)
//   DEPTH  number of entries (>= 4, any value)
//   CW     count width, derived as $clog2(DEPTH+1); leave at default
//
// Ports
//   clk                 rising-edge system clock
//   rst                 asynchronous active-low reset
//   clear               synchronous flush, wins over push/pop
//   push / pop          operation requests for this cycle
//   data_in             word to push (also the bypass/replace source)
//   data_out            last popped word (registered)
//   out_valid           1 in the cycle after an accepted pop/replace/bypass
//   count               number of stored entries, 0..DEPTH
//   empty / full        count == 0 / count == DEPTH
//   half_full           count >= DEPTH/2
//   three_quarter_full  count >= (3*DEPTH)/4
//   overflow            sticky: a push was rejected on a full stack
//   underflow           sticky: a pop was rejected on an empty stack
// -----------------------------------------------------------------------------
module stack_lifo_param #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             half_full,
   output logic             three_quarter_full,
   output logic             overflow,
   output logic             underflow
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [CW-1:0] LVL_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] LVL_HALF = CW'(DEPTH / 2);
   localparam logic [CW-1:0] LVL_TQ   = CW'((3 * DEPTH) / 4);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_data_out;
   logic             r_out_valid;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_empty;
   logic             w_full;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_top_idx;
   logic             w_push_ok;
   logic             w_pop_ok;
   logic             w_replace;
   logic             w_bypass;
   logic             w_push_rej;
   logic             w_pop_rej;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == LVL_FULL);

   // count < DEPTH whenever these are used, so truncation to AW is safe.
   assign w_wr_idx  = AW'(r_count);
   assign w_top_idx = AW'(r_count - CW'(1));

   // Operation decode. clear masks every operation for the cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would infer a latch.
      w_push_ok  = 1'b0;
      w_pop_ok   = 1'b0;
      w_replace  = 1'b0;
      w_bypass   = 1'b0;
      w_push_rej = 1'b0;
      w_pop_rej  = 1'b0;
      if (!clear) begin
         unique case ({push, pop})
            2'b10: begin
               w_push_ok  = !w_full;
               w_push_rej = w_full;
            end
            2'b01: begin
               w_pop_ok  = !w_empty;
               w_pop_rej = w_empty;
            end
            2'b11: begin
               w_replace = !w_empty;
               w_bypass  = w_empty;
            end
            default: ;
         endcase
      end
   end

   // NOTE: storage has no reset; contents are only meaningful below count, so
   // clearing them would cost a reset tree for nothing.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[w_wr_idx] <= data_in;
      end else if (w_replace) begin
         r_mem[w_top_idx] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count     <= '0;
         r_data_out  <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here, so the replace path reads the
         // pre-edge top word while the memory block overwrites it.
         r_out_valid <= 1'b0;
         if (clear) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end else begin
            if (w_push_ok) begin
               r_count <= r_count + CW'(1);
            end
            if (w_pop_ok) begin
               r_count <= r_count - CW'(1);
            end
            if (w_pop_ok || w_replace) begin
               r_data_out  <= r_mem[w_top_idx];
               r_out_valid <= 1'b1;
            end
            if (w_bypass) begin
               r_data_out  <= data_in;
               r_out_valid <= 1'b1;
            end
            if (w_push_rej) begin
               r_overflow <= 1'b1;
            end
            if (w_pop_rej) begin
               r_underflow <= 1'b1;
            end
         end
      end
   end

   assign data_out           = r_data_out;
   assign out_valid          = r_out_valid;
   assign count              = r_count;
   assign empty              = w_empty;
   assign full               = w_full;
   assign half_full          = (r_count >= LVL_HALF);
   assign three_quarter_full = (r_count >= LVL_TQ);
   assign overflow           = r_overflow;
   assign underflow          = r_underflow;

endmodule

// File: tb/tb_stack_lifo_param.sv
// -----------------------------------------------------------------------------
// tb_stack_lifo_param
//
// Directed bench for stack_lifo_param. Instance a is DEPTH=16/WIDTH=32,
// instance b is DEPTH=6/WIDTH=8. Single-edge operations come from a vector
// table; fill, thresholds, mid-cycle reset and the odd depth are sequences.
// -----------------------------------------------------------------------------
module tb_stack_lifo_param;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // Instance a: 16 x 32
   logic        a_clear = 1'b0, a_push = 1'b0, a_pop = 1'b0;
   logic [31:0] a_din = '0;
   logic [31:0] a_dout;
   logic        a_vld;
   logic [4:0]  a_cnt;
   logic        a_empty, a_full, a_half, a_tq, a_ovf, a_udf;

   stack_lifo_param #(.WIDTH(32), .DEPTH(16)) u_a (
      .clk(clk), .rst(rst), .clear(a_clear), .push(a_push), .pop(a_pop),
      .data_in(a_din), .data_out(a_dout), .out_valid(a_vld), .count(a_cnt),
      .empty(a_empty), .full(a_full), .half_full(a_half),
      .three_quarter_full(a_tq), .overflow(a_ovf), .underflow(a_udf)
   );

   // Instance b: 6 x 8, count is 3 bits wide
   logic        b_clear = 1'b0, b_push = 1'b0, b_pop = 1'b0;
   logic [7:0]  b_din = '0;
   logic [7:0]  b_dout;
   logic        b_vld;
   logic [2:0]  b_cnt;
   logic        b_empty, b_full, b_half, b_tq, b_ovf, b_udf;

   stack_lifo_param #(.WIDTH(8), .DEPTH(6)) u_b (
      .clk(clk), .rst(rst), .clear(b_clear), .push(b_push), .pop(b_pop),
      .data_in(b_din), .data_out(b_dout), .out_valid(b_vld), .count(b_cnt),
      .empty(b_empty), .full(b_full), .half_full(b_half),
      .three_quarter_full(b_tq), .overflow(b_ovf), .underflow(b_udf)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        push, pop, clear;
      logic [31:0] din;
      logic [31:0] e_dout;
      logic        e_vld;
      logic [4:0]  e_cnt;
      logic        e_empty, e_ovf, e_udf;
   } vec_t;

   function automatic vec_t mk(input bit pu, input bit po, input bit cl,
                               input logic [31:0] d, input logic [31:0] ed,
                               input bit ev, input int ec, input bit ee,
                               input bit eo, input bit eu);
      vec_t v;
      v.push = pu; v.pop = po; v.clear = cl; v.din = d;
      v.e_dout = ed; v.e_vld = ev; v.e_cnt = 5'(ec);
      v.e_empty = ee; v.e_ovf = eo; v.e_udf = eu;
      return v;
   endfunction

   // Push 0..15 into instance a, checking the level flags at every count.
   task automatic fill_a(input string tag);
      for (int i = 0; i < 16; i++) begin
         a_push = 1'b1;
         a_din  = 32'(i);
         tick();
         check($sformatf("%s cnt%0d count", tag, i + 1), 32'(a_cnt), 32'(i + 1));
         check($sformatf("%s cnt%0d half", tag, i + 1), 32'(a_half), 32'((i + 1) >= 8));
         check($sformatf("%s cnt%0d tq", tag, i + 1), 32'(a_tq), 32'((i + 1) >= 12));
         check($sformatf("%s cnt%0d full", tag, i + 1), 32'(a_full), 32'((i + 1) == 16));
      end
      a_push = 1'b0;
   endtask

   vec_t vecs[20];

   initial begin
      //                 pu po cl din           e_dout        ev cnt em ov un
      vecs[0]  = mk(1, 0, 0, 32'hABCD, 32'h0,    0, 1, 0, 0, 0);
      vecs[1]  = mk(1, 0, 0, 32'h1234, 32'h0,    0, 2, 0, 0, 0);
      vecs[2]  = mk(1, 0, 0, 32'h2345, 32'h0,    0, 3, 0, 0, 0);
      vecs[3]  = mk(0, 1, 0, 32'h0,    32'h2345, 1, 2, 0, 0, 0);
      vecs[4]  = mk(0, 1, 0, 32'h0,    32'h1234, 1, 1, 0, 0, 0);
      vecs[5]  = mk(0, 1, 0, 32'h0,    32'hABCD, 1, 0, 1, 0, 0);
      vecs[6]  = mk(0, 0, 0, 32'h0,    32'hABCD, 0, 0, 1, 0, 0);
      // underflow, sticky through a legal push, cleared by clear
      vecs[7]  = mk(0, 1, 0, 32'h0,    32'hABCD, 0, 0, 1, 0, 1);
      vecs[8]  = mk(1, 0, 0, 32'h5,    32'hABCD, 0, 1, 0, 0, 1);
      vecs[9]  = mk(0, 0, 1, 32'h0,    32'hABCD, 0, 0, 1, 0, 0);
      // replace-top and bypass
      vecs[10] = mk(1, 0, 0, 32'hA,    32'hABCD, 0, 1, 0, 0, 0);
      vecs[11] = mk(1, 0, 0, 32'hB,    32'hABCD, 0, 2, 0, 0, 0);
      vecs[12] = mk(1, 1, 0, 32'hC,    32'hB,    1, 2, 0, 0, 0);
      vecs[13] = mk(0, 1, 0, 32'h0,    32'hC,    1, 1, 0, 0, 0);
      vecs[14] = mk(0, 1, 0, 32'h0,    32'hA,    1, 0, 1, 0, 0);
      vecs[15] = mk(1, 1, 0, 32'h77,   32'h77,   1, 0, 1, 0, 0);
      vecs[16] = mk(0, 0, 0, 32'h0,    32'h77,   0, 0, 1, 0, 0);
      // clear beats push; the ignored push leaves the stack empty
      vecs[17] = mk(1, 0, 1, 32'h55,   32'h77,   0, 0, 1, 0, 0);
      vecs[18] = mk(0, 1, 0, 32'h0,    32'h77,   0, 0, 1, 0, 1);
      vecs[19] = mk(0, 0, 1, 32'h0,    32'h77,   0, 0, 1, 0, 0);

      // Reset for two cycles
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset count", 32'(a_cnt), 32'd0);
      check("reset empty", 32'(a_empty), 32'd1);
      check("reset half", 32'(a_half), 32'd0);
      check("reset full", 32'(a_full), 32'd0);
      check("reset dout", a_dout, 32'h0);
      check("reset vld", 32'(a_vld), 32'd0);
      check("reset ovf", 32'(a_ovf), 32'd0);
      check("reset udf", 32'(a_udf), 32'd0);
      rst = 1'b1;

      // Table-driven single-edge operations
      for (int i = 0; i < 20; i++) begin
         a_push  = vecs[i].push;
         a_pop   = vecs[i].pop;
         a_clear = vecs[i].clear;
         a_din   = vecs[i].din;
         tick();
         check($sformatf("v%0d dout", i), a_dout, vecs[i].e_dout);
         check($sformatf("v%0d vld", i), 32'(a_vld), 32'(vecs[i].e_vld));
         check($sformatf("v%0d count", i), 32'(a_cnt), 32'(vecs[i].e_cnt));
         check($sformatf("v%0d empty", i), 32'(a_empty), 32'(vecs[i].e_empty));
         check($sformatf("v%0d ovf", i), 32'(a_ovf), 32'(vecs[i].e_ovf));
         check($sformatf("v%0d udf", i), 32'(a_udf), 32'(vecs[i].e_udf));
      end
      a_push = 1'b0; a_pop = 1'b0; a_clear = 1'b0;

      // Fill, rejected 17th push, first pop returns the last word
      fill_a("fill1");
      a_push = 1'b1; a_din = 32'h99;
      tick();
      a_push = 1'b0;
      check("push17 count", 32'(a_cnt), 32'd16);
      check("push17 ovf", 32'(a_ovf), 32'd1);
      check("push17 full", 32'(a_full), 32'd1);
      a_pop = 1'b1;
      tick();
      a_pop = 1'b0;
      check("pop after full dout", a_dout, 32'hF);
      check("pop after full vld", 32'(a_vld), 32'd1);
      check("pop after full count", 32'(a_cnt), 32'd15);
      check("ovf sticky", 32'(a_ovf), 32'd1);

      // Replace-top on a full stack raises no error
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      check("clear ovf", 32'(a_ovf), 32'd0);
      fill_a("fill2");
      a_push = 1'b1; a_pop = 1'b1; a_din = 32'hEE;
      tick();
      a_push = 1'b0; a_pop = 1'b0;
      check("full replace dout", a_dout, 32'hF);
      check("full replace vld", 32'(a_vld), 32'd1);
      check("full replace count", 32'(a_cnt), 32'd16);
      check("full replace ovf", 32'(a_ovf), 32'd0);
      check("full replace udf", 32'(a_udf), 32'd0);
      a_pop = 1'b1;
      tick();
      a_pop = 1'b0;
      check("pop replaced top", a_dout, 32'hEE);

      // Asynchronous reset between edges
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_push = 1'b1;
         a_din  = 32'h100 + 32'(i);
         tick();
      end
      a_push = 1'b0;
      a_pop  = 1'b1;
      tick();
      a_pop = 1'b0;
      check("pre-reset dout", a_dout, 32'h104);
      check("pre-reset vld", 32'(a_vld), 32'd1);
      check("pre-reset count", 32'(a_cnt), 32'd4);
      #2;
      rst = 1'b0;
      #1;
      check("async rst count", 32'(a_cnt), 32'd0);
      check("async rst dout", a_dout, 32'h0);
      check("async rst vld", 32'(a_vld), 32'd0);
      check("async rst empty", 32'(a_empty), 32'd1);
      #1;
      rst = 1'b1;
      a_pop = 1'b1;
      tick();
      a_pop = 1'b0;
      check("post-reset pop udf", 32'(a_udf), 32'd1);
      check("post-reset pop vld", 32'(a_vld), 32'd0);
      check("post-reset pop count", 32'(a_cnt), 32'd0);

      // Odd depth: DEPTH=6 thresholds 3 / 4 / 6, exact LIFO order
      b_clear = 1'b1;
      tick();
      b_clear = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         b_push = 1'b1;
         b_din  = 8'(8'h11 * i);
         tick();
         check($sformatf("b push%0d count", i), 32'(b_cnt), 32'(i));
         check($sformatf("b push%0d half", i), 32'(b_half), 32'(i >= 3));
         check($sformatf("b push%0d tq", i), 32'(b_tq), 32'(i >= 4));
         check($sformatf("b push%0d full", i), 32'(b_full), 32'(i == 6));
      end
      b_push = 1'b0;
      for (int i = 6; i >= 1; i--) begin
         b_pop = 1'b1;
         tick();
         check($sformatf("b pop%0d dout", 7 - i), 32'(b_dout), 32'(8'h11 * i));
         check($sformatf("b pop%0d vld", 7 - i), 32'(b_vld), 32'd1);
         check($sformatf("b pop%0d count", 7 - i), 32'(b_cnt), 32'(i - 1));
      end
      b_pop = 1'b0;
      check("b empty", 32'(b_empty), 32'd1);
      check("b udf", 32'(b_udf), 32'd0);
      check("b ovf", 32'(b_ovf), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
